// File: rtl/if_stage_if.sv
// Fetch-stage bus: control from the hazard/EX units, instruction memory port,
// and the IF/ID pipeline register seen by decode.
interface if_stage_if;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic [31:0] if_id_pc;
  logic [31:0] if_id_pc4;
  logic [31:0] if_id_instr;
  logic        if_id_valid;
  logic        misalign_err;
  logic [31:0] fetch_count;

  modport master (
    output stall, redirect_valid, redirect_target, imem_rdata,
    input  imem_addr, if_id_pc, if_id_pc4, if_id_instr, if_id_valid,
           misalign_err, fetch_count
  );

  modport slave (
    input  stall, redirect_valid, redirect_target, imem_rdata,
    output imem_addr, if_id_pc, if_id_pc4, if_id_instr, if_id_valid,
           misalign_err, fetch_count
  );
endinterface

// File: rtl/if_stage.sv
// RV32IM instruction fetch stage: owns the PC, fills the IF/ID register and
// handles load-use stalls and EX-resolved redirects.
module if_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        reset,
  if_stage_if.slave   bus
);

  logic [31:0] r_pc;
  logic [31:0] r_if_id_pc;
  logic [31:0] r_if_id_pc4;
  logic [31:0] r_if_id_instr;
  logic        r_if_id_valid;
  logic        r_misalign_err;
  logic [31:0] r_fetch_count;

  logic [31:0] w_pc_plus4;
  logic [31:0] w_pc_next;
  logic [31:0] w_if_id_pc_next;
  logic [31:0] w_if_id_pc4_next;
  logic [31:0] w_if_id_instr_next;
  logic        w_if_id_valid_next;
  logic        w_misalign_next;
  logic [31:0] w_fetch_count_next;

  // Next-state selection: redirect beats stall, stall beats a normal fetch.
  always_comb begin
    w_pc_plus4         = r_pc + 32'd4;
    w_pc_next          = r_pc;
    w_if_id_pc_next    = r_if_id_pc;
    w_if_id_pc4_next   = r_if_id_pc4;
    w_if_id_instr_next = r_if_id_instr;
    w_if_id_valid_next = r_if_id_valid;
    w_fetch_count_next = r_fetch_count;
    w_misalign_next    = r_misalign_err;
    if (bus.redirect_valid) begin
      // Wrong-path word on imem_rdata is dropped; the target is force-aligned.
      w_pc_next          = {bus.redirect_target[31:2], 2'b00};
      w_if_id_pc_next    = 32'h0000_0000;
      w_if_id_pc4_next   = 32'h0000_0000;
      w_if_id_instr_next = NOP_INSTR;
      w_if_id_valid_next = 1'b0;
      w_misalign_next    = r_misalign_err | (bus.redirect_target[1:0] != 2'b00);
    end else if (bus.stall) begin
      w_pc_next          = r_pc;
    end else begin
      w_pc_next          = w_pc_plus4;
      w_if_id_pc_next    = r_pc;
      w_if_id_pc4_next   = w_pc_plus4;
      w_if_id_instr_next = bus.imem_rdata;
      w_if_id_valid_next = 1'b1;
      w_fetch_count_next = r_fetch_count + 32'd1;
    end
  end

  // State register with synchronous reset taking priority over everything.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pc           <= RESET_PC;
      r_if_id_pc     <= 32'h0000_0000;
      r_if_id_pc4    <= 32'h0000_0000;
      r_if_id_instr  <= NOP_INSTR;
      r_if_id_valid  <= 1'b0;
      r_misalign_err <= 1'b0;
      r_fetch_count  <= 32'h0000_0000;
    end else begin
      r_pc           <= w_pc_next;
      r_if_id_pc     <= w_if_id_pc_next;
      r_if_id_pc4    <= w_if_id_pc4_next;
      r_if_id_instr  <= w_if_id_instr_next;
      r_if_id_valid  <= w_if_id_valid_next;
      r_misalign_err <= w_misalign_next;
      r_fetch_count  <= w_fetch_count_next;
    end
  end

  assign bus.imem_addr    = r_pc;
  assign bus.if_id_pc     = r_if_id_pc;
  assign bus.if_id_pc4    = r_if_id_pc4;
  assign bus.if_id_instr  = r_if_id_instr;
  assign bus.if_id_valid  = r_if_id_valid;
  assign bus.misalign_err = r_misalign_err;
  assign bus.fetch_count  = r_fetch_count;

endmodule

// File: tb/tb_if_stage.sv
// Directed, table-driven bench for if_stage with a small combinational imem.
module tb_if_stage;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_errors;

  if_stage_if bus ();

  if_stage #(
    .RESET_PC  (32'h0000_0000),
    .NOP_INSTR (32'h0000_0013)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] imem_word(input logic [31:0] a);
    logic [31:0] r;
    case (a)
      32'h0000_0000: r = 32'h0050_0093;
      32'h0000_0004: r = 32'h00a0_0113;
      32'h0000_0008: r = 32'h0000_0013;
      32'h0000_000C: r = 32'h0020_81b3;
      32'h0000_0010: r = 32'h0010_0193;
      32'h0000_0014: r = 32'h0020_0213;
      32'h0000_0018: r = 32'h0030_0293;
      32'h0000_001C: r = 32'h0040_0313;
      default:       r = 32'hFFFF_FFFF ^ a;
    endcase
    return r;
  endfunction

  assign bus.imem_rdata = imem_word(bus.imem_addr);

  typedef struct {
    logic        stall;
    logic        redir;
    logic [31:0] target;
    logic [31:0] pc;
    logic [31:0] ipc;
    logic [31:0] ipc4;
    logic [31:0] instr;
    logic        valid;
    logic        mis;
    logic [31:0] cnt;
  } vec_t;

  vec_t vecs [16];

  function automatic vec_t mk(input logic s, input logic r, input logic [31:0] t,
                              input logic [31:0] pc, input logic [31:0] ipc,
                              input logic [31:0] ipc4, input logic [31:0] instr,
                              input logic v, input logic m, input logic [31:0] c);
    vec_t x;
    x.stall = s; x.redir = r; x.target = t; x.pc = pc; x.ipc = ipc;
    x.ipc4 = ipc4; x.instr = instr; x.valid = v; x.mis = m; x.cnt = c;
    return x;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [31:0] pc, input logic [31:0] ipc,
                         input logic [31:0] ipc4, input logic [31:0] instr,
                         input logic v, input logic m, input logic [31:0] c);
    chk({tag, ".imem_addr"},    bus.imem_addr, pc);
    chk({tag, ".if_id_pc"},     bus.if_id_pc, ipc);
    chk({tag, ".if_id_pc4"},    bus.if_id_pc4, ipc4);
    chk({tag, ".if_id_instr"},  bus.if_id_instr, instr);
    chk({tag, ".if_id_valid"},  {31'd0, bus.if_id_valid}, {31'd0, v});
    chk({tag, ".misalign_err"}, {31'd0, bus.misalign_err}, {31'd0, m});
    chk({tag, ".fetch_count"},  bus.fetch_count, c);
  endtask

  task automatic step(input logic s, input logic r, input logic [31:0] t, input logic rst);
    @(negedge clk);
    bus.stall           = s;
    bus.redirect_valid  = r;
    bus.redirect_target = t;
    reset               = rst;
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    reset = 1'b1;
    bus.stall = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_target = 32'h0000_0000;

    //            stall redir target          pc             if_pc          if_pc4         instr          v     mis   cnt
    vecs[0]  = mk(1'b0, 1'b0, 32'h0000_0000, 32'h0000_0004, 32'h0000_0000, 32'h0000_0004, 32'h0050_0093, 1'b1, 1'b0, 32'd1);
    vecs[1]  = mk(1'b0, 1'b0, 32'h0000_0000, 32'h0000_0008, 32'h0000_0004, 32'h0000_0008, 32'h00a0_0113, 1'b1, 1'b0, 32'd2);
    vecs[2]  = mk(1'b1, 1'b0, 32'h0000_0000, 32'h0000_0008, 32'h0000_0004, 32'h0000_0008, 32'h00a0_0113, 1'b1, 1'b0, 32'd2);
    vecs[3]  = mk(1'b1, 1'b0, 32'h0000_0000, 32'h0000_0008, 32'h0000_0004, 32'h0000_0008, 32'h00a0_0113, 1'b1, 1'b0, 32'd2);
    vecs[4]  = mk(1'b0, 1'b0, 32'h0000_0000, 32'h0000_000C, 32'h0000_0008, 32'h0000_000C, 32'h0000_0013, 1'b1, 1'b0, 32'd3);
    vecs[5]  = mk(1'b0, 1'b1, 32'h0000_0014, 32'h0000_0014, 32'h0000_0000, 32'h0000_0000, 32'h0000_0013, 1'b0, 1'b0, 32'd3);
    vecs[6]  = mk(1'b0, 1'b0, 32'h0000_0000, 32'h0000_0018, 32'h0000_0014, 32'h0000_0018, 32'h0020_0213, 1'b1, 1'b0, 32'd4);
    vecs[7]  = mk(1'b1, 1'b1, 32'h0000_001C, 32'h0000_001C, 32'h0000_0000, 32'h0000_0000, 32'h0000_0013, 1'b0, 1'b0, 32'd4);
    vecs[8]  = mk(1'b1, 1'b0, 32'h0000_0000, 32'h0000_001C, 32'h0000_0000, 32'h0000_0000, 32'h0000_0013, 1'b0, 1'b0, 32'd4);
    vecs[9]  = mk(1'b0, 1'b0, 32'h0000_0000, 32'h0000_0020, 32'h0000_001C, 32'h0000_0020, 32'h0040_0313, 1'b1, 1'b0, 32'd5);
    vecs[10] = mk(1'b0, 1'b1, 32'h0000_0016, 32'h0000_0014, 32'h0000_0000, 32'h0000_0000, 32'h0000_0013, 1'b0, 1'b1, 32'd5);
    vecs[11] = mk(1'b0, 1'b1, 32'h0000_0008, 32'h0000_0008, 32'h0000_0000, 32'h0000_0000, 32'h0000_0013, 1'b0, 1'b1, 32'd5);
    vecs[12] = mk(1'b0, 1'b0, 32'h0000_0000, 32'h0000_000C, 32'h0000_0008, 32'h0000_000C, 32'h0000_0013, 1'b1, 1'b1, 32'd6);
    vecs[13] = mk(1'b0, 1'b1, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 32'h0000_0000, 32'h0000_0000, 32'h0000_0013, 1'b0, 1'b1, 32'd6);
    vecs[14] = mk(1'b0, 1'b0, 32'h0000_0000, 32'h0000_0000, 32'hFFFF_FFFC, 32'h0000_0000, 32'h0000_0003, 1'b1, 1'b1, 32'd7);
    vecs[15] = mk(1'b0, 1'b0, 32'h0000_0000, 32'h0000_0004, 32'h0000_0000, 32'h0000_0004, 32'h0050_0093, 1'b1, 1'b1, 32'd8);

    // Reset state, with stall and redirect asserted to show reset wins.
    step(1'b1, 1'b1, 32'h0000_0040, 1'b1);
    step(1'b0, 1'b0, 32'h0000_0000, 1'b1);
    chk_all("reset", 32'h0, 32'h0, 32'h0, 32'h0000_0013, 1'b0, 1'b0, 32'd0);

    for (int i = 0; i < 16; i++) begin
      step(vecs[i].stall, vecs[i].redir, vecs[i].target, 1'b0);
      chk_all($sformatf("vec%0d", i), vecs[i].pc, vecs[i].ipc, vecs[i].ipc4,
              vecs[i].instr, vecs[i].valid, vecs[i].mis, vecs[i].cnt);
    end

    // Sticky misalign survives further idle cycles, cleared only by reset.
    step(1'b1, 1'b0, 32'h0000_0000, 1'b0);
    chk("mis_sticky", {31'd0, bus.misalign_err}, 32'd1);

    // Reset during a redirect: nothing of the redirect is remembered.
    step(1'b0, 1'b1, 32'h0000_0030, 1'b1);
    chk_all("rst_mid_redir", 32'h0, 32'h0, 32'h0, 32'h0000_0013, 1'b0, 1'b0, 32'd0);
    step(1'b0, 1'b0, 32'h0000_0000, 1'b0);
    chk_all("post_rst", 32'h4, 32'h0, 32'h4, 32'h0050_0093, 1'b1, 1'b0, 32'd1);

    // Redirect held for three cycles yields three bubbles at the same target.
    for (int k = 0; k < 3; k++) begin
      step(1'b0, 1'b1, 32'h0000_0010, 1'b0);
      chk_all($sformatf("hold_redir%0d", k), 32'h10, 32'h0, 32'h0, 32'h0000_0013,
              1'b0, 1'b0, 32'd1);
    end
    step(1'b0, 1'b0, 32'h0000_0000, 1'b0);
    chk_all("after_hold", 32'h14, 32'h10, 32'h14, 32'h0010_0193, 1'b1, 1'b0, 32'd2);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/if_stage.md
Name: if_stage

Overview:
- Instruction fetch stage of the RV32IM 5-stage pipeline.
- Owns the program counter and drives the instruction-memory address.
- Captures the returned word plus PC metadata into the IF/ID pipeline register consumed by the decode stage.
- Handles stall (load-use hazard) and redirect/flush (taken branch or jump resolved in EX), and keeps a fetch counter for debug.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- NOP_INSTR, 32'h0000_0013, bubble encoding inserted on flush or reset (addi x0,x0,0).

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- stall  input  1  hazard unit request to hold PC and IF/ID.
- redirect_valid  input  1  EX-stage taken branch/jump; flush IF/ID and load new PC.
- redirect_target  input  32  target byte address for the redirect.
- imem_addr  output  32  byte address to instruction memory; equals the pc register.
- imem_rdata  input  32  instruction word at imem_addr, little-endian assembled, combinational read.
- if_id_pc  output  32  PC of the instruction held in IF/ID.
- if_id_pc4  output  32  if_id_pc + 4, used as the link value.
- if_id_instr  output  32  instruction held in IF/ID.
- if_id_valid  output  1  1 = real instruction, 0 = bubble.
- misalign_err  output  1  sticky flag: a redirect target had nonzero bits [1:0].
- fetch_count  output  32  number of valid instructions written into IF/ID.

Behaviour:
- Reset, checked at the clock edge:
  - pc = RESET_PC.
  - if_id_pc = 0, if_id_pc4 = 0, if_id_instr = NOP_INSTR, if_id_valid = 0.
  - misalign_err = 0, fetch_count = 0.
  - Reset overrides stall and redirect in the same cycle.
- imem_addr = pc, combinational; the memory returns imem_rdata in the same cycle.
- Fetch latency: the word at address A appears on if_id_instr one cycle after pc = A.
- Priority per cycle: reset > redirect_valid > stall > normal.
- Normal (no stall, no redirect):
  - pc <= pc + 4.
  - if_id_pc <= pc, if_id_pc4 <= pc + 4, if_id_instr <= imem_rdata, if_id_valid <= 1.
  - fetch_count += 1.
- Stall only:
  - pc and all IF/ID fields hold their values.
  - fetch_count holds.
- Redirect (wins over a simultaneous stall):
  - pc <= {redirect_target[31:2], 2'b00}.
  - if_id_instr <= NOP_INSTR, if_id_valid <= 0, if_id_pc and if_id_pc4 <= 0.
  - fetch_count holds.
  - The wrong-path word on imem_rdata that cycle is discarded.
- Misaligned redirect: if redirect_valid and redirect_target[1:0] != 0, misalign_err <= 1. It stays 1 until reset; the PC is force-aligned as above.
- Arithmetic:
  - pc + 4 is 32-bit modulo: 32'hFFFF_FFFC wraps to 0 with no error.
  - fetch_count wraps from 32'hFFFF_FFFF to 0.
- First fetch after reset deasserts: the cycle reset is low, pc = RESET_PC; IF/ID becomes valid at the next edge.
- Reset asserted mid-stall or mid-redirect: the reset values apply at that edge; no pending redirect is remembered.
- Back-to-back redirects: each is honoured and the last one wins. A redirect held for N cycles produces N bubbles.
- Stall while if_id_valid = 0: the bubble is held and stays invalid.

Test Plan:
- Sequential fetch: imem holds 0x00500093, 0x00a00113, 0x00000013, 0x002081b3 at 0x0–0xC; release reset -> if_id_instr shows those words on consecutive cycles with if_id_pc 0, 4, 8, C; fetch_count = 4 after the fourth.
- Stall: assert stall for 2 cycles while IF/ID holds 0x00a00113 at pc 4 -> IF/ID, imem_addr = 8 and fetch_count are frozen for both cycles; the next edge loads 0x00000013 at pc 8.
- Redirect: redirect_valid = 1, target 0x14, while pc = 0xC -> next edge if_id_valid = 0 and if_id_instr = 0x00000013, pc = 0x14; the following edge gives if_id_pc = 0x14 with valid = 1.
- Redirect + stall in the same cycle -> redirect wins: pc = target and a bubble is inserted.
- Misaligned target 0x16 -> pc = 0x14, misalign_err = 1, and it stays 1 until reset asserts for one cycle.
- Wrap: force pc via redirect to 0xFFFFFFFC -> the next normal cycle gives pc = 0 and if_id_pc4 = 0.
